// File: rtl/fp_normalize_round_pipe.sv
// Two-stage normalise/round pipeline for the FP adder: S1 normalises (carry shift, leading-zero
// shift, gradual underflow), S2 rounds in one of four modes and packs sign/exponent/fraction/flags.
module fp_normalize_round_pipe #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sign,
    input  logic [EXP_W-1:0] in_exp,
    input  logic [MAN_W:0]   in_man,
    input  logic             in_carry,
    input  logic [2:0]       in_grs,
    input  logic [1:0]       rm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sign,
    output logic [EXP_W-1:0] out_exp,
    output logic [MAN_W-1:0] out_frac,
    output logic [3:0]       out_flags
);

    localparam int unsigned M     = MAN_W + 1;
    localparam int unsigned LzW   = $clog2(M + 1);
    localparam int unsigned CmpW  = ((EXP_W > LzW) ? EXP_W : LzW) + 1;
    localparam int unsigned PackW = EXP_W + MAN_W;

    logic s1En, s2En, s1Valid;

    assign s2En     = !out_valid || out_ready;
    assign s1En     = !s1Valid || s2En;
    assign in_ready = s1En;

    logic [LzW-1:0] lz;
    logic           lzFound;

    always_comb begin
        lz      = '0;
        lzFound = 1'b0;
        for (int i = M - 1; i >= 0; i--) begin
            if (!lzFound) begin
                if (in_man[i]) begin
                    lzFound = 1'b1;
                end else begin
                    lz = lz + LzW'(1);
                end
            end
        end
    end

    logic [M+1:0]     grVec, grShifted;
    logic [CmpW-1:0]  lzExt, expExt, shAmt;
    logic [M-1:0]     n1Man;
    logic [EXP_W-1:0] n1Exp;
    logic [2:0]       n1Grs;

    always_comb begin
        lzExt     = CmpW'(lz);
        expExt    = CmpW'(in_exp);
        grVec     = {in_man, in_grs[2], in_grs[1]};
        shAmt     = '0;
        grShifted = '0;
        n1Man     = '0;
        n1Exp     = '0;
        n1Grs     = '0;
        if (in_carry) begin
            n1Man = {1'b1, in_man[MAN_W:1]};
            n1Exp = in_exp + EXP_W'(1);
            n1Grs = {in_man[0], in_grs[2], in_grs[1] | in_grs[0]};
        end else if (in_man != '0 || in_grs != 3'b000) begin
            // Normalise fully if the exponent allows it, otherwise stop at the subnormal boundary
            if (lzExt < expExt) begin
                shAmt = lzExt;
                n1Exp = in_exp - EXP_W'(lz);
            end else begin
                shAmt = (expExt == '0) ? '0 : expExt - CmpW'(1);
                n1Exp = '0;
            end
            grShifted = grVec << shAmt;
            n1Man     = grShifted[M+1:2];
            n1Grs     = {grShifted[1:0], in_grs[0]};
        end
    end

    logic             s1Sign;
    logic [EXP_W-1:0] s1Exp;
    logic [M-1:0]     s1Man;
    logic [2:0]       s1Grs;
    logic [1:0]       s1Rm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1Valid <= 1'b0;
            s1Sign  <= 1'b0;
            s1Exp   <= '0;
            s1Man   <= '0;
            s1Grs   <= '0;
            s1Rm    <= '0;
        end else if (s1En) begin
            s1Valid <= in_valid;
            if (in_valid) begin
                s1Sign <= in_sign;
                s1Exp  <= n1Exp;
                s1Man  <= n1Man;
                s1Grs  <= n1Grs;
                s1Rm   <= rm;
            end
        end
    end

    logic             anyGrs, roundUp, overflow, toInf, inexact;
    logic [PackW-1:0] rounded;
    logic [EXP_W-1:0] fExp;
    logic [MAN_W-1:0] fFrac;

    always_comb begin
        anyGrs  = |s1Grs;
        roundUp = 1'b0;
        case (s1Rm)
            2'd0:    roundUp = s1Grs[2] & (s1Grs[1] | s1Grs[0] | s1Man[0]);
            2'd1:    roundUp = 1'b0;
            2'd2:    roundUp = anyGrs & !s1Sign;
            default: roundUp = anyGrs & s1Sign;
        endcase
        // Exponent and fraction increment as one word so fraction carry-out bumps the exponent
        rounded  = {s1Exp, s1Man[MAN_W-1:0]} + PackW'(roundUp);
        fExp     = rounded[PackW-1:MAN_W];
        fFrac    = rounded[MAN_W-1:0];
        overflow = (s1Exp == '1) || (fExp == '1);
        toInf    = (s1Rm == 2'd0) || (s1Rm == 2'd2 && !s1Sign) || (s1Rm == 2'd3 && s1Sign);
        if (overflow) begin
            fExp  = toInf ? '1 : {{(EXP_W-1){1'b1}}, 1'b0};
            fFrac = toInf ? '0 : '1;
        end
        inexact = anyGrs || overflow;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sign  <= 1'b0;
            out_exp   <= '0;
            out_frac  <= '0;
            out_flags <= '0;
        end else if (s2En) begin
            out_valid <= s1Valid;
            if (s1Valid) begin
                out_sign  <= s1Sign;
                out_exp   <= fExp;
                out_frac  <= fFrac;
                out_flags <= {overflow, (fExp == '0) && (fFrac != '0) && inexact, inexact,
                              (fExp == '0) && (fFrac == '0)};
            end
        end
    end

endmodule

// File: tb/tb_fp_normalize_round_pipe.sv
// Bench for fp_normalize_round_pipe: directed vectors with hand-derived results plus a random
// back-pressured stream checked in order against a reference model through a queue.
module tb_fp_normalize_round_pipe;

    typedef logic [35:0] res_t;  // {sign, exp[7:0], frac[22:0], flags[3:0]}
    typedef struct packed {
        logic        sg;
        logic [7:0]  ex;
        logic [23:0] mn;
        logic        cy;
        logic [2:0]  grs;
        logic [1:0]  rm;
        res_t        want;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_sign, in_carry;
    logic [7:0]  in_exp;
    logic [23:0] in_man;
    logic [2:0]  in_grs;
    logic [1:0]  rm;
    logic        out_valid, out_ready, out_sign;
    logic [7:0]  out_exp;
    logic [22:0] out_frac;
    logic [3:0]  out_flags;

    res_t expQ[$];
    res_t pendExp;
    int   passCnt = 0;
    int   checkCnt = 0;

    fp_normalize_round_pipe #(.EXP_W(8), .MAN_W(23)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_exp(in_exp), .in_man(in_man), .in_carry(in_carry),
        .in_grs(in_grs), .rm(rm), .out_valid(out_valid), .out_ready(out_ready),
        .out_sign(out_sign), .out_exp(out_exp), .out_frac(out_frac), .out_flags(out_flags)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

    function automatic res_t model(logic sg, logic [7:0] ex, logic [23:0] mn, logic cy,
                                   logic [2:0] grs, logic [1:0] rmode);
        int          lz, sh, e;
        logic [25:0] v;
        logic [23:0] m;
        logic        g, r, s, up, ovf, toInf, inx;
        longint      mag, fe, ff;
        lz = 24;
        for (int i = 0; i < 24; i++) if (mn[i]) lz = 23 - i;
        if (cy) begin
            m = {1'b1, mn[23:1]}; e = int'(ex) + 1; g = mn[0]; r = grs[2]; s = grs[1] | grs[0];
        end else if (mn == 0 && grs == 0) begin
            m = 0; e = 0; g = 0; r = 0; s = 0;
        end else begin
            if (lz < int'(ex)) begin
                sh = lz; e = int'(ex) - lz;
            end else begin
                sh = (ex == 0) ? 0 : int'(ex) - 1; e = 0;
            end
            v = {mn, grs[2], grs[1]};
            v = v << sh;
            m = v[25:2]; g = v[1]; r = v[0]; s = grs[0];
        end
        case (rmode)
            2'd0:    up = g & (r | s | m[0]);
            2'd1:    up = 1'b0;
            2'd2:    up = (g | r | s) & !sg;
            default: up = (g | r | s) & sg;
        endcase
        mag = longint'(e) * 64'd8388608 + longint'(m[22:0]) + longint'(up);
        fe = mag / 8388608;
        ff = mag % 8388608;
        ovf = (e >= 255) || (fe >= 255);
        toInf = (rmode == 2'd0) || (rmode == 2'd2 && !sg) || (rmode == 2'd3 && sg);
        if (ovf) begin
            fe = toInf ? 255 : 254;
            ff = toInf ? 0 : 64'h7FFFFF;
        end
        inx = g | r | s | ovf;
        return {sg, 8'(fe), 23'(ff), ovf, (fe == 0) && (ff != 0) && inx, inx, (fe == 0) && (ff == 0)};
    endfunction

    function automatic vec_t mk(logic sg, logic [7:0] ex, logic [23:0] mn, logic cy,
                                logic [2:0] grs, logic [1:0] rmode, logic [7:0] wExp,
                                logic [22:0] wFrac, logic [3:0] wFlags);
        return '{sg: sg, ex: ex, mn: mn, cy: cy, grs: grs, rm: rmode,
                 want: {sg, wExp, wFrac, wFlags}};
    endfunction

    // One clock: sample handshakes just before the edge, log accepted beats, return at negedge.
    task automatic step_cycle(output logic ov, output logic fired, output res_t got);
        #1;
        ov    = out_valid;
        fired = out_valid & out_ready;
        got   = {out_sign, out_exp, out_frac, out_flags};
        if (in_valid && in_ready) expQ.push_back(pendExp);
        @(negedge clk);
    endtask

    task automatic drive_vec(input vec_t v);
        in_sign = v.sg; in_exp = v.ex; in_man = v.mn; in_carry = v.cy; in_grs = v.grs; rm = v.rm;
        pendExp = v.want;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checkCnt++;
        if (out_valid !== 1'b0 || {out_sign, out_exp, out_frac, out_flags} !== 36'h0) begin
            $display("FAIL reset_outputs: got v=%b %h want v=0 000000000", out_valid,
                     {out_sign, out_exp, out_frac, out_flags});
        end else passCnt++;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkCnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        end else passCnt++;
        @(negedge clk);
    endtask

    task automatic test_latency();
        logic ov, fired;
        res_t got, want;
        vec_t v;
        v = mk(1'b0, 8'h80, 24'h000001, 1'b0, 3'b000, 2'd0, 8'h69, 23'h0, 4'h0);
        out_ready = 1'b1;
        drive_vec(v);
        in_valid = 1'b1;
        step_cycle(ov, fired, got);
        in_valid = 1'b0;
        step_cycle(ov, fired, got);
        checkCnt++;
        if (ov !== 1'b0) $display("FAIL latency_early: got valid=%b want 0", ov);
        else passCnt++;
        step_cycle(ov, fired, got);
        checkCnt++;
        if (ov !== 1'b1) $display("FAIL latency_two: got valid=%b want 1", ov);
        else passCnt++;
        if (fired && expQ.size() > 0) begin
            want = expQ.pop_front();
            checkCnt++;
            if (got !== want) $display("FAIL latency_data: got %h want %h", got, want);
            else passCnt++;
        end
        expQ.delete();
    endtask

    task automatic test_back_to_back();
        vec_t dir[15];
        logic ov, fired;
        res_t got, want;
        int   notReady = 0;
        dir[0]  = mk(0, 8'h7F, 24'h800000, 1, 3'b100, 2'd0, 8'h80, 23'h400000, 4'h2);
        dir[1]  = mk(0, 8'h80, 24'h000001, 0, 3'b000, 2'd0, 8'h69, 23'h000000, 4'h0);
        dir[2]  = mk(0, 8'h03, 24'h000010, 0, 3'b010, 2'd0, 8'h00, 23'h000041, 4'h0);
        dir[3]  = mk(0, 8'hFE, 24'hFFFFFF, 1, 3'b000, 2'd0, 8'hFF, 23'h000000, 4'hA);
        dir[4]  = mk(0, 8'hFE, 24'hFFFFFF, 1, 3'b000, 2'd1, 8'hFE, 23'h7FFFFF, 4'hA);
        dir[5]  = mk(1, 8'h80, 24'hFFFFFF, 0, 3'b110, 2'd0, 8'h81, 23'h000000, 4'h2);
        dir[6]  = mk(1, 8'h80, 24'hFFFFFF, 0, 3'b110, 2'd1, 8'h80, 23'h7FFFFF, 4'h2);
        dir[7]  = mk(1, 8'h80, 24'hFFFFFF, 0, 3'b110, 2'd2, 8'h80, 23'h7FFFFF, 4'h2);
        dir[8]  = mk(1, 8'h80, 24'hFFFFFF, 0, 3'b110, 2'd3, 8'h81, 23'h000000, 4'h2);
        dir[9]  = mk(1, 8'h50, 24'h000000, 0, 3'b000, 2'd0, 8'h00, 23'h000000, 4'h1);
        dir[10] = mk(0, 8'h01, 24'h7FFFFF, 0, 3'b100, 2'd0, 8'h01, 23'h000000, 4'h2);
        dir[11] = mk(0, 8'h01, 24'h000003, 0, 3'b001, 2'd2, 8'h00, 23'h000004, 4'h6);
        dir[12] = mk(0, 8'hFE, 24'hFFFFFE, 1, 3'b000, 2'd3, 8'hFE, 23'h7FFFFF, 4'hA);
        dir[13] = mk(0, 8'hFE, 24'hFFFFFF, 0, 3'b100, 2'd0, 8'hFF, 23'h000000, 4'hA);
        dir[14] = mk(0, 8'h80, 24'h800000, 0, 3'b100, 2'd0, 8'h80, 23'h000000, 4'h2);
        out_ready = 1'b1;
        for (int i = 0; i < 15 + 4; i++) begin
            in_valid = (i < 15);
            if (i < 15) drive_vec(dir[i]);
            if (in_valid && !in_ready) notReady++;
            step_cycle(ov, fired, got);
            if (fired) begin
                checkCnt++;
                if (expQ.size() == 0) begin
                    $display("FAIL directed_extra: got %h want no output", got);
                end else begin
                    want = expQ.pop_front();
                    if (got !== want) $display("FAIL directed_result: got %h want %h", got, want);
                    else passCnt++;
                end
            end
        end
        checkCnt++;
        if (notReady != 0 || expQ.size() != 0)
            $display("FAIL directed_throughput: got stalls=%0d left=%0d want 0 0",
                     notReady, expQ.size());
        else passCnt++;
    endtask

    task automatic test_reset_midstream();
        logic ov, fired;
        res_t got;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        drive_vec(mk(0, 8'hFE, 24'hFFFFFF, 1, 3'b000, 2'd0, 8'hFF, 23'h0, 4'hA));
        step_cycle(ov, fired, got);
        drive_vec(mk(0, 8'h80, 24'h000001, 0, 3'b000, 2'd0, 8'h69, 23'h0, 4'h0));
        step_cycle(ov, fired, got);
        in_valid = 1'b0;
        step_cycle(ov, fired, got);
        checkCnt++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1)
            $display("FAIL stall_full: got rdy=%b v=%b want rdy=0 v=1", in_ready, out_valid);
        else passCnt++;
        #2 reset = 1'b1;
        #1;
        checkCnt++;
        if (out_valid !== 1'b0 || {out_sign, out_exp, out_frac, out_flags} !== 36'h0)
            $display("FAIL reset_midstream: got v=%b %h want v=0 000000000", out_valid,
                     {out_sign, out_exp, out_frac, out_flags});
        else passCnt++;
        expQ.delete();
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        checkCnt++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0)
            $display("FAIL reset_mid_release: got rdy=%b v=%b want rdy=1 v=0", in_ready, out_valid);
        else passCnt++;
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkCnt++;
        if (out_valid !== 1'b0) $display("FAIL reset_flushed: got valid=%b want 0", out_valid);
        else passCnt++;
    endtask

    task automatic test_random_stream();
        logic ov, fired, prevStall;
        res_t got, want, prevGot;
        prevStall = 1'b0;
        prevGot   = '0;
        for (int n = 0; n < 400 + 30; n++) begin
            in_valid  = (n < 400) && ($urandom_range(0, 9) < 7);
            in_sign   = 1'($urandom);
            in_exp    = 8'($urandom_range(0, 254));
            in_man    = 24'($urandom) >> $urandom_range(0, 23);
            in_carry  = ($urandom_range(0, 3) == 0);
            in_grs    = 3'($urandom);
            rm        = 2'($urandom);
            out_ready = (n >= 400) ? 1'b1 : 1'($urandom);
            pendExp   = model(in_sign, in_exp, in_man, in_carry, in_grs, rm);
            step_cycle(ov, fired, got);
            if (prevStall) begin
                checkCnt++;
                if (ov !== 1'b1 || got !== prevGot)
                    $display("FAIL stall_stable: got v=%b %h want v=1 %h", ov, got, prevGot);
                else passCnt++;
            end
            if (fired) begin
                checkCnt++;
                if (expQ.size() == 0) begin
                    $display("FAIL random_extra: got %h want no output", got);
                end else begin
                    want = expQ.pop_front();
                    if (got !== want) $display("FAIL random_result: got %h want %h", got, want);
                    else passCnt++;
                end
            end
            prevStall = ov && !fired;
            prevGot   = got;
        end
        checkCnt++;
        if (expQ.size() != 0) $display("FAIL random_dropped: got %0d left want 0", expQ.size());
        else passCnt++;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_man = '0;
        in_carry = 1'b0; in_grs = '0; rm = '0; out_ready = 1'b0; pendExp = '0;
        #2;
        test_reset();
        test_latency();
        test_back_to_back();
        test_reset_midstream();
        test_random_stream();
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
